pq_cmd_rx: RTL and testbench
============================

// Module: pq_cmd_rx
// PURPOSE
//  Serial command front end for the priority-queue demo: receives 8N1 UART bytes from the host and
//  decodes them into insert/remove requests for the queue core. Sits at board top level beside
//  the seven-segment/RGB display path; it supplies input to the core, which that path displays.
//  Frames: 'I'(0x49) key val = insert(key,val); 'R'(0x52) = remove highest priority.
// PARAMETERS
//  CLK_FREQ      100_000_000  clock frequency, Hz
//  BAUD          9600         line rate; BIT_TICKS = CLK_FREQ/BAUD (integer divide, >= 4)
//  TIMEOUT_BITS  40           inter-byte timeout in bit times (used only with PQ_CMD_TIMEOUT_EN)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active high
//  rx           in   1  UART line, idle high, asynchronous to clk
//  cmd_valid    out  1  request pending; held until accepted
//  cmd_ready    in   1  core accepts request when cmd_valid && cmd_ready
//  cmd_op       out  1  0 = insert, 1 = remove
//  cmd_key      out  8  insert priority key (0 on remove)
//  cmd_val      out  8  insert data value (0 on remove)
//  busy         out  1  parser not in P_IDLE
//  framing_err  out  1  1-cycle pulse: stop bit sampled low
//  bad_cmd      out  1  1-cycle pulse: unknown opcode byte
//  overrun      out  1  1-cycle pulse: byte dropped while request pending
//  timeout      out  1  1-cycle pulse: partial frame abandoned (0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0; parser P_IDLE; receiver R_IDLE; bit/tick counters 0; rx sync flops = 1.
//  rx passes 2-flop synchronizer; all decisions use synchronized value (2-cycle input latency).
//  Receiver FSM R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE:
//   - R_IDLE: falling edge of synced rx (prev 1, now 0) -> R_START, tick count cleared.
//   - R_START: at BIT_TICKS/2 resample; 1 = glitch, back to R_IDLE, no pulse; 0 -> R_DATA.
//   - R_DATA: sample every BIT_TICKS, LSB first, 8 bits into shift reg.
//   - R_STOP: sample after BIT_TICKS; 1 -> byte strobe (1 cycle); 0 -> framing_err, byte discarded.
//   - Back in R_IDLE the same cycle as stop sample; back-to-back frames accepted.
//  Parser FSM (acts on byte strobe only):
//   - P_IDLE: 0x49 -> P_KEY; 0x52 -> P_ISSUE with op=1, key=val=0; other -> bad_cmd, stay.
//   - P_KEY: byte -> key reg, P_VAL.  P_VAL: byte -> val reg, op=0, P_ISSUE.
//   - P_ISSUE: cmd_valid=1 from cycle after final strobe; op/key/val stable while valid.
//     On cmd_valid && cmd_ready: cmd_valid=0 next cycle, P_IDLE. Held indefinitely without ready.
//   - Byte strobe in P_ISSUE: byte dropped, overrun pulse, request unaffected.
//   - Strobe coinciding with acceptance cycle: also dropped (overrun), P_IDLE next.
//  Opcode bytes are not special inside P_KEY/P_VAL: 0x49 may be a key or value.
//  framing_err during P_KEY/P_VAL: parser state unchanged (bad byte simply not counted).
//  Mid-operation rst: any partial frame or pending request discarded; cmd_valid 0 next cycle;
//   receiver rearms only on a fresh falling edge (line held low through reset is ignored).
//  cmd_key/cmd_val/cmd_op retain last values after acceptance until next request loads.
// CONFIGURATION
//  PQ_CMD_TIMEOUT_EN defined: counter runs in P_KEY/P_VAL, cleared on every byte strobe;
//   reaching TIMEOUT_BITS*BIT_TICKS cycles -> P_IDLE, timeout pulse, partial key discarded.
//   Counter idle in P_IDLE/P_ISSUE (pending request never times out).
//  Undefined: P_KEY/P_VAL wait forever; timeout tied 0; no counter logic synthesized.
// TESTING  (CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clk/bit; cmd_ready=1 unless noted)
//  Send 0x49,0x05,0xA3 -> one cmd_valid cycle, op=0 key=0x05 val=0xA3; busy 0 afterwards.
//  Send 0x52 with cmd_ready=0 for 50 cycles -> cmd_valid held, op=1, key=val=0; clears 1 cycle after ready.
//  Send 0x49,0x07,0x11 then 0x52 while ready=0 -> overrun pulse once; first request intact.
//  Byte 0x49 with stop bit 0 -> framing_err pulse, parser stays P_IDLE; 3-cycle low glitch -> nothing.
//  Send 0x58 -> bad_cmd pulse; then 0x52 -> remove issued normally.
//  Send 0x49,0x02, idle 400 cycles -> timeout pulse, P_IDLE (macro on); macro off: stays P_VAL,
//   next byte 0x33 issues insert key=0x02 val=0x33. Assert rst mid-frame -> all outputs 0.

Source files
------------

// File: rtl/pq_cmd_rx.sv
// UART 8N1 command receiver/decoder feeding the priority-queue core.
// Optional PQ_CMD_TIMEOUT_EN abandons stalled partial frames.
module pq_cmd_rx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_op,
  output logic [7:0] cmd_key,
  output logic [7:0] cmd_val,
  output logic       busy,
  output logic       framing_err,
  output logic       bad_cmd,
  output logic       overrun,
  output logic       timeout
);

  localparam int BIT_TICKS = CLK_FREQ / BAUD;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int TW        = $clog2(BIT_TICKS + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);

  if (BIT_TICKS < 4 || TIMEOUT_BITS < 1) begin : g_bad_cfg
    $error("pq_cmd_rx: bad BIT_TICKS or TIMEOUT_BITS");
  end

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } r_state_t;

  typedef enum logic [1:0] {
    P_IDLE, P_KEY, P_VAL, P_ISSUE
  } p_state_t;

  logic       rx_s1, rx_s2, rx_prev;
  logic       armed;
  logic [1:0] settle;
  logic       fall;

  // armed only after a genuine high is seen, so a line held low
  // through reset cannot fake a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (settle != 2'd2)
        settle <= settle + 2'd1;
      else if (rx_s2)
        armed <= 1'b1;
    end
  end

  assign fall = armed & rx_prev & ~rx_s2;

  r_state_t        r_state, r_next;
  logic [TW-1:0]   tick, tick_d;
  logic [2:0]      bit_cnt, bit_d;
  logic [7:0]      shreg, sh_d;
  logic            rx_stb, rx_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      r_state <= r_next;
      tick    <= tick_d;
      bit_cnt <= bit_d;
      shreg   <= sh_d;
    end
  end

  always_comb begin
    r_next  = r_state;
    tick_d  = tick + TW'(1);
    bit_d   = bit_cnt;
    sh_d    = shreg;
    rx_stb  = 1'b0;
    rx_ferr = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (fall) r_next = R_START;
      end
      R_START: begin
        if (tick == HALF_LAST) begin
          tick_d = '0;
          r_next = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (tick == BIT_LAST) begin
          tick_d = '0;
          sh_d   = {rx_s2, shreg[7:1]};
          bit_d  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) r_next = R_STOP;
        end
      end
      R_STOP: begin
        if (tick == BIT_LAST) begin
          tick_d = '0;
          r_next = R_IDLE;
          if (rx_s2) rx_stb  = 1'b1;
          else       rx_ferr = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  p_state_t   p_state, p_next;
  logic [7:0] key_q;
  logic       ld_key, iss_ins, iss_rem;
  logic       bad_d, ovr_d, to_hit;

`ifdef PQ_CMD_TIMEOUT_EN
  localparam int TO_LIM = TIMEOUT_BITS * BIT_TICKS;
  localparam int CW     = $clog2(TO_LIM + 1);
  logic [CW-1:0] to_cnt;
  logic          in_frame;

  assign in_frame = (p_state == P_KEY) || (p_state == P_VAL);
  assign to_hit   = in_frame && (to_cnt == CW'(TO_LIM - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_hit;
      if (in_frame && !rx_stb && !to_hit)
        to_cnt <= to_cnt + CW'(1);
      else
        to_cnt <= '0;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    p_next  = p_state;
    ld_key  = 1'b0;
    iss_ins = 1'b0;
    iss_rem = 1'b0;
    bad_d   = 1'b0;
    ovr_d   = 1'b0;
    unique case (p_state)
      P_IDLE: begin
        if (rx_stb) begin
          unique case (1'b1)
            (shreg == 8'h49): p_next = P_KEY;
            (shreg == 8'h52): begin
              iss_rem = 1'b1;
              p_next  = P_ISSUE;
            end
            default: bad_d = 1'b1;
          endcase
        end
      end
      P_KEY: begin
        if (to_hit) begin
          p_next = P_IDLE;
        end else if (rx_stb) begin
          ld_key = 1'b1;
          p_next = P_VAL;
        end
      end
      P_VAL: begin
        if (to_hit) begin
          p_next = P_IDLE;
        end else if (rx_stb) begin
          iss_ins = 1'b1;
          p_next  = P_ISSUE;
        end
      end
      P_ISSUE: begin
        ovr_d = rx_stb;
        if (cmd_ready) p_next = P_IDLE;
      end
      default: p_next = P_IDLE;
    endcase
  end

  // request fields load only on issue so they hold after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state     <= P_IDLE;
      key_q       <= '0;
      cmd_op      <= 1'b0;
      cmd_key     <= '0;
      cmd_val     <= '0;
      framing_err <= 1'b0;
      bad_cmd     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      p_state     <= p_next;
      framing_err <= rx_ferr;
      bad_cmd     <= bad_d;
      overrun     <= ovr_d;
      if (ld_key) key_q <= shreg;
      if (iss_ins) begin
        cmd_op  <= 1'b0;
        cmd_key <= key_q;
        cmd_val <= shreg;
      end else if (iss_rem) begin
        cmd_op  <= 1'b1;
        cmd_key <= '0;
        cmd_val <= '0;
      end
    end
  end

  assign cmd_valid = (p_state == P_ISSUE);
  assign busy      = (p_state != P_IDLE);

endmodule

// File: tb/tb_pq_cmd_rx.sv
// Bench for pq_cmd_rx: directed UART frames, scoreboard of expected
// requests and per-cycle handshake/hold checks. 10 clk per bit.
module tb_pq_cmd_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid, cmd_op, busy;
  logic [7:0] cmd_key, cmd_val;
  logic       framing_err, bad_cmd, overrun, timeout;

  pq_cmd_rx #(
    .CLK_FREQ(1_000_000),
    .BAUD(100_000),
    .TIMEOUT_BITS(40)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_val(cmd_val),
    .busy(busy), .framing_err(framing_err), .bad_cmd(bad_cmd),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       op;
    logic [7:0] key;
    logic [7:0] val;
  } cmd_t;

  int   total = 0, bad = 0;
  cmd_t exp_q[$];
  cmd_t last_acc = '0, pv_cmd = '0, cur, want;
  int   n_ferr = 0, n_bad = 0, n_ovr = 0, n_to = 0;
  int   n_acc = 0, n_vcyc = 0;
  logic pv_valid = 1'b0, pv_acc = 1'b0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    cur = {cmd_op, cmd_key, cmd_val};
    if (rst) begin
      exp_q.delete();
      last_acc = '0;
      pv_valid = 1'b0;
      pv_acc   = 1'b0;
    end else begin
      if (framing_err) n_ferr++;
      if (bad_cmd)     n_bad++;
      if (overrun)     n_ovr++;
      if (timeout)     n_to++;
      if (cmd_valid)   n_vcyc++;
      if (pv_acc)
        chk(!cmd_valid, "valid_drop", cmd_valid, 0);
      else if (pv_valid && cmd_valid)
        chk(cur == pv_cmd, "hold", cur, pv_cmd);
      if (!cmd_valid)
        chk(cur == last_acc, "retain", cur, last_acc);
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        chk(exp_q.size() != 0, "cmd_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk(cur == want, "cmd_fields", cur, want);
        end
        last_acc = cur;
      end
      pv_valid = cmd_valid;
      pv_acc   = cmd_valid && cmd_ready;
      pv_cmd   = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) tick();
    end
    rx = stop;
    repeat (10) tick();
    rx = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_acc(input int target, input string name);
    for (int i = 0; i < 300 && n_acc < target; i++) tick();
    chk(n_acc >= target, name, n_acc, target);
  endtask

  task automatic chk_zero(input string name);
    @(negedge clk);
    chk({cmd_valid, busy, framing_err, bad_cmd, overrun, timeout,
         cmd_op, cmd_key, cmd_val} == '0, name,
        {cmd_valid, busy, framing_err, bad_cmd, overrun, timeout,
         cmd_op, cmd_key, cmd_val}, 0);
  endtask

  int a0, v0, o0, f0, b0, t0, s0;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk_zero("reset_outputs");
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // insert 05/A3 with ready high: exactly one valid cycle
    cmd_ready = 1'b1;
    a0 = n_acc;
    v0 = n_vcyc;
    exp_q.push_back({1'b0, 8'h05, 8'hA3});
    send_byte(8'h49, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hA3, 1'b1);
    wait_acc(a0 + 1, "t1_accept");
    repeat (3) tick();
    chk(n_vcyc - v0 == 1, "t1_valid_cycles", n_vcyc - v0, 1);
    chk({cmd_op, cmd_key, cmd_val} == 17'h005A3, "t1_fields",
        {cmd_op, cmd_key, cmd_val}, 17'h005A3);
    chk(busy == 1'b0, "t1_busy", busy, 0);

    // remove held while not ready
    cmd_ready = 1'b0;
    a0 = n_acc;
    exp_q.push_back({1'b1, 8'h00, 8'h00});
    send_byte(8'h52, 1'b1);
    repeat (50) tick();
    chk(cmd_valid == 1'b1, "t2_held", cmd_valid, 1);
    chk({cmd_op, cmd_key, cmd_val} == 17'h10000, "t2_fields",
        {cmd_op, cmd_key, cmd_val}, 17'h10000);
    cmd_ready = 1'b1;
    wait_acc(a0 + 1, "t2_accept");

    // overrun while insert pending
    cmd_ready = 1'b0;
    a0 = n_acc;
    o0 = n_ovr;
    exp_q.push_back({1'b0, 8'h07, 8'h11});
    send_byte(8'h49, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h52, 1'b1);
    repeat (5) tick();
    chk(n_ovr - o0 == 1, "t3_overrun", n_ovr - o0, 1);
    chk(cmd_valid && cmd_key == 8'h07 && cmd_val == 8'h11, "t3_intact",
        {cmd_valid, cmd_key, cmd_val}, 17'h10711);
    cmd_ready = 1'b1;
    wait_acc(a0 + 1, "t3_accept");
    repeat (20) tick();
    chk(busy == 1'b0 && n_acc == a0 + 1, "t3_idle", {busy, n_acc[7:0]}, 0);

    // framing error then a short glitch
    f0 = n_ferr;
    send_byte(8'h49, 1'b0);
    repeat (5) tick();
    chk(n_ferr - f0 == 1, "t4_ferr", n_ferr - f0, 1);
    chk(busy == 1'b0, "t4_busy", busy, 0);
    s0 = n_ferr + n_bad + n_ovr + n_to + n_vcyc;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (40) tick();
    chk(n_ferr + n_bad + n_ovr + n_to + n_vcyc == s0 && !busy,
        "t4_glitch", n_ferr + n_bad + n_ovr + n_to + n_vcyc, s0);

    // bad opcode, then a normal remove
    b0 = n_bad;
    a0 = n_acc;
    send_byte(8'h58, 1'b1);
    repeat (5) tick();
    chk(n_bad - b0 == 1, "t5_bad_cmd", n_bad - b0, 1);
    exp_q.push_back({1'b1, 8'h00, 8'h00});
    send_byte(8'h52, 1'b1);
    wait_acc(a0 + 1, "t5_accept");

    // partial frame left idle
    t0 = n_to;
    a0 = n_acc;
    send_byte(8'h49, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (420) tick();
`ifdef PQ_CMD_TIMEOUT_EN
    chk(n_to - t0 == 1, "t6_timeout", n_to - t0, 1);
    chk(busy == 1'b0, "t6_idle", busy, 0);
    exp_q.push_back({1'b1, 8'h00, 8'h00});
    send_byte(8'h52, 1'b1);
    wait_acc(a0 + 1, "t6_accept");
`else
    chk(busy == 1'b1 && n_to == t0, "t6_waiting", {busy, n_to[7:0]}, 9'h100);
    exp_q.push_back({1'b0, 8'h02, 8'h33});
    send_byte(8'h33, 1'b1);
    wait_acc(a0 + 1, "t6_accept");
`endif

    // reset mid-operation, line held low through reset
    cmd_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h00, 8'h00});
    send_byte(8'h52, 1'b1);
    repeat (3) tick();
    chk(cmd_valid == 1'b1, "t7_pending", cmd_valid, 1);
    rx = 1'b0;
    repeat (25) tick();
    rst = 1'b1;
    tick();
    chk_zero("t7_reset_outputs");
    repeat (2) tick();
    rst = 1'b0;
    s0 = n_ferr + n_bad + n_ovr + n_to + n_vcyc;
    repeat (40) tick();
    rx = 1'b1;
    repeat (40) tick();
    chk(n_ferr + n_bad + n_ovr + n_to + n_vcyc == s0 && !busy,
        "t7_quiet", n_ferr + n_bad + n_ovr + n_to + n_vcyc, s0);
    cmd_ready = 1'b1;
    a0 = n_acc;
    exp_q.push_back({1'b1, 8'h00, 8'h00});
    send_byte(8'h52, 1'b1);
    wait_acc(a0 + 1, "t7_accept");
    repeat (5) tick();
    chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
